// File: rtl/input_debouncer.sv
// input_debouncer: per-channel synchroniser, stable-count debouncer and
// one-cycle rise/fall pulse generator for asynchronous board inputs.
// Optional sticky event register with masked acknowledge and interrupt,
// enabled by defining INPUT_DEBOUNCER_EVENT_LATCH_EN.
module input_debouncer #(
    parameter int unsigned      WIDTH           = 16,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 1000000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] value_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    input  logic             ack_i,
    input  logic [WIDTH-1:0] ack_mask_i,
    output logic [WIDTH-1:0] event_pending_o,
    output logic             irq_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] samp_q;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Synchroniser chain plus a sample register of the last stage; the
    // debouncer compares against the sample, giving an acceptance latency of
    // SYNC_STAGES + DEBOUNCE_CYCLES edges from first capture.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= RESET_VALUE;
            end
            samp_q <= RESET_VALUE;
        end else begin
            sync_q[0] <= async_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            samp_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Per-channel stable-count decision: restart on agreement, accept on the
    // last count of the window, otherwise keep counting.
    always_comb begin
        value_d = value_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int n = 0; n < int'(WIDTH); n++) begin
            cnt_d[n] = cnt_q[n];
            if (samp_q[n] == value_q[n]) begin
                cnt_d[n] = '0;
            end else if (cnt_q[n] == CNT_MAX) begin
                value_d[n] = samp_q[n];
                cnt_d[n]   = '0;
                rise_d[n]  = samp_q[n];
                fall_d[n]  = ~samp_q[n];
            end else begin
                cnt_d[n] = cnt_q[n] + CNT_W'(1);
            end
        end
    end

    // Debounce state and registered level/pulse outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            value_q <= RESET_VALUE;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int n = 0; n < int'(WIDTH); n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            value_q <= value_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int n = 0; n < int'(WIDTH); n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign value_o = value_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

`ifdef INPUT_DEBOUNCER_EVENT_LATCH_EN
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_d;
    logic             irq_q;

    // Sticky flags: masked acknowledge clears, a concurrent pulse re-sets.
    always_comb begin
        pending_d = pending_q;
        if (ack_i) begin
            pending_d = pending_d & ~ack_mask_i;
        end
        pending_d = pending_d | rise_q | fall_q;
    end

    // Event flags and interrupt, the interrupt lagging the flags by a cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            irq_q     <= |pending_q;
        end
    end

    assign event_pending_o = pending_q;
    assign irq_o           = irq_q;
`else
    logic unused_ack;

    // Event register absent: outputs tied low, acknowledge inputs ignored.
    assign unused_ack      = ^{ack_i, ack_mask_i};
    assign event_pending_o = '0;
    assign irq_o           = 1'b0;
`endif

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Parametrised conditioning block for asynchronous board-level inputs such as the switch bank and buttons; replaces raw wiring of those inputs into the chipset.
- Per channel: synchronises, debounces by stable-count, and emits one-cycle rise/fall pulses.
- Optional sticky event register with masked acknowledge lets the CPU poll or take an interrupt on input changes.
- Sits at board level between the async pins and the chipset, clocked in the CPU domain.

Parameters:
- WIDTH, 16, number of independent input channels.
- SYNC_STAGES, 2, synchroniser flop depth; legal range ≥2.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level; legal range ≥2; counter width is $clog2(DEBOUNCE_CYCLES).
- RESET_VALUE, '0, WIDTH-bit reset level for the synchroniser chain and value_o.

Ports:
- clk_i  input  1  block clock (CPU domain)
- reset_i  input  1  reset; asynchronous, active-high
- async_i  input  WIDTH  raw asynchronous inputs
- value_o  output  WIDTH  debounced level per channel
- rise_o  output  WIDTH  one-cycle pulse on an accepted 0→1 transition
- fall_o  output  WIDTH  one-cycle pulse on an accepted 1→0 transition
- ack_i  input  1  acknowledge strobe for the event register
- ack_mask_i  input  WIDTH  channels cleared when ack_i=1
- event_pending_o  output  WIDTH  sticky per-channel change flags
- irq_o  output  1  OR-reduction of event_pending_o

Behaviour:
- Interface: one clock (clk_i); reset_i is asynchronous and active-high.
- Reset values:
  - Synchroniser stages and value_o = RESET_VALUE.
  - Counters = 0.
  - rise_o, fall_o, event_pending_o and irq_o = 0.
- Synchroniser: async_i[n] enters stage 1 on each clk_i edge. The last stage, s[n], is the only signal the debouncer sees. No other logic touches async_i.
- Per-channel debounce state (counter cnt[n], level v[n]=value_o[n]), evaluated each clock:
  - If s[n]==v[n]: cnt[n]←0. No pulse.
  - Else if cnt[n]==DEBOUNCE_CYCLES-1: v[n]←s[n] and cnt[n]←0. Assert rise_o[n] if s[n]=1, otherwise fall_o[n], for exactly one cycle, concurrent with the new value_o.
  - Else: cnt[n]←cnt[n]+1.
- Any return to the old level during counting restarts the window. There is no hysteresis beyond this rule.
- Latency: for a clean edge held stable, value_o changes SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the edge that first captures the new level into stage 1.
- Channels are fully independent. Any number of channels may accept transitions in the same cycle, in either direction.
- rise_o[n] and fall_o[n] are never asserted together. A channel cannot accept two transitions within DEBOUNCE_CYCLES cycles.
- The counter never wraps: the maximum value reached is DEBOUNCE_CYCLES-1.
- Reset mid-count: all state returns to reset values immediately. After release, a full window is required again. No pulses are generated by reset itself or by its release.
- value_o, rise_o and fall_o are registered outputs with no combinational path from any input.

Optional Feature:
- Macro: INPUT_DEBOUNCER_EVENT_LATCH_EN.
- Defined:
  - event_pending_o[n] is set on rise_o[n] or fall_o[n].
  - It is cleared on a cycle with ack_i=1 and ack_mask_i[n]=1.
  - Simultaneous set and clear: set wins, so the flag stays 1.
  - ack_i=0 ignores ack_mask_i.
  - irq_o = |event_pending_o, registered (one cycle after the flag).
- Undefined: event_pending_o and irq_o are tied 0; ack_i and ack_mask_i are unused; no event-register flops are synthesised.

Test Plan (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_VALUE=4'b0000, macro defined unless noted):
- Reset: hold reset_i=1 with async_i=4'b1111 → value_o=0000, rise_o=fall_o=0000, event_pending_o=0000, irq_o=0 throughout. Release with async_i=0000 → no pulses.
- Clean rise: async_i[0] 0→1 captured at edge k and held → value_o[0]=1 and rise_o[0]=1 after edge k+6, pulse one cycle wide. Next cycle event_pending_o=0001; the following cycle irq_o=1.
- Bounce rejection: async_i[1] high for 3 cycles then low, repeated 5 times → value_o[1] stays 0; no rise/fall pulses; event_pending_o[1]=0.
- Simultaneous channels: from value_o=0100, drive async_i[2]→0 and async_i[3]→1 on the same edge → fall_o=0100 and rise_o=1000 in the same cycle; value_o=1000.
- Ack collision: event_pending_o=0001; pulse ack_i with ack_mask_i=0001 in the same cycle as fall_o[0] → flag remains 1. A later ack with mask 0001 → flag 0 and irq_o 0 next cycle. Ack with mask 0010 → no effect on bit 0.
- Reset mid-debounce: assert reset_i while cnt[0]=2 with the new level pending → value_o[0] returns to 0 immediately, no pulse. After release with the level still applied, acceptance takes the full 6 edges again. Build with the macro undefined → event_pending_o and irq_o stay 0 for all of the above.
